// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-flight branch prediction queue with resolve, train and flush
// Oldest-first FIFO of predictions; a mispredicting resolve flushes the queue and redirects fetch.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int GHR_W = 3,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  input  logic [PC_W-1:0]          pred_fallthru,
  input  logic [GHR_W-1:0]         pred_ghr,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic [GHR_W-1:0]         upd_ghr,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [GHR_W-1:0]         ghr_restore,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  typedef enum logic {ST_RUN, ST_RECOVER} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_upd_valid;
  logic              r_upd_taken;
  logic [GHR_W-1:0]  r_upd_ghr;
  logic              r_flush;
  logic [PC_W-1:0]   r_redirect_pc;
  logic [GHR_W-1:0]  r_ghr_restore;
  logic              r_proto_err;

  logic              r_mem_taken    [DEPTH];
  logic [PC_W-1:0]   r_mem_target   [DEPTH];
  logic [PC_W-1:0]   r_mem_fallthru [DEPTH];
  logic [GHR_W-1:0]  r_mem_ghr      [DEPTH];

  logic              w_pred_ready;
  logic              w_res_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_head_taken;
  logic [PC_W-1:0]   w_head_target;
  logic [PC_W-1:0]   w_head_fallthru;
  logic [GHR_W-1:0]  w_head_ghr;
  logic              w_mispredict;
  logic              w_err;

  // Readiness comes only from registered state so it never depends on res_valid.
  assign w_pred_ready = (r_state == ST_RUN) && (r_count < LP_DEPTH);
  assign w_res_ready  = (r_state == ST_RUN) && (r_count != '0);
  assign w_push       = pred_valid && w_pred_ready;
  assign w_pop        = res_valid && w_res_ready;

  assign w_head_taken    = r_mem_taken[r_rptr];
  assign w_head_target   = r_mem_target[r_rptr];
  assign w_head_fallthru = r_mem_fallthru[r_rptr];
  assign w_head_ghr      = r_mem_ghr[r_rptr];

  assign w_mispredict = w_pop && ((res_taken != w_head_taken) ||
                                  (res_taken && (res_target != w_head_target)));

  assign w_err = (r_state == ST_RUN) &&
                 ((res_valid && !w_res_ready) || (pred_valid && !w_pred_ready));

  // A push that coincides with a mispredict is wrong-path and is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !w_mispredict) begin
      r_mem_taken[r_wptr]    <= pred_taken;
      r_mem_target[r_wptr]   <= pred_target;
      r_mem_fallthru[r_wptr] <= pred_fallthru;
      r_mem_ghr[r_wptr]      <= pred_ghr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_taken   <= 1'b0;
      r_upd_ghr     <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_ghr_restore <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      r_flush     <= w_mispredict;
      r_proto_err <= r_proto_err | w_err;
      if (w_pop) begin
        r_upd_taken <= res_taken;
        r_upd_ghr   <= w_head_ghr;
      end
      if (w_mispredict) begin
        r_redirect_pc <= res_taken ? res_target : w_head_fallthru;
        r_ghr_restore <= {res_taken, w_head_ghr[GHR_W-1:1]};
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_count       <= '0;
        r_state       <= ST_RECOVER;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        r_state <= ST_RUN;
      end
    end
  end

  assign pred_ready  = w_pred_ready;
  assign res_ready   = w_res_ready;
  assign upd_valid   = r_upd_valid;
  assign upd_taken   = r_upd_taken;
  assign upd_ghr     = r_upd_ghr;
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign ghr_restore = r_ghr_restore;
  assign count       = r_count;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed table and sequence bench for branch_resolve_queue
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target, pred_fallthru;
  logic [2:0]  pred_ghr;
  logic        pred_ready;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        res_ready;
  logic        upd_valid, upd_taken;
  logic [2:0]  upd_ghr;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  ghr_restore;
  logic [2:0]  count;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .GHR_W(3), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthru(pred_fallthru), .pred_ghr(pred_ghr), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
    .flush(flush), .redirect_pc(redirect_pc), .ghr_restore(ghr_restore),
    .count(count), .proto_err(proto_err)
  );

  typedef struct {
    logic        rst, pv, pt;
    logic [31:0] ptgt, pfall;
    logic [2:0]  pghr;
    logic        rv, rt;
    logic [31:0] rtgt;
    logic        e_pr, e_rr, e_uv, e_ut;
    logic [2:0]  e_ug;
    logic        e_fl;
    logic [31:0] e_rpc;
    logic [2:0]  e_gr;
    logic [2:0]  e_cnt;
    logic        e_pe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, pv, pt, input logic [31:0] ptgt, pfall, input logic [2:0] pghr,
                     input logic rv, rt, input logic [31:0] rtgt,
                     input logic pr, rr, uv, ut, input logic [2:0] ug, input logic fl,
                     input logic [31:0] rpc, input logic [2:0] gr, cnt, input logic pe);
    vec_t v;
    v.rst = r; v.pv = pv; v.pt = pt; v.ptgt = ptgt; v.pfall = pfall; v.pghr = pghr;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt;
    v.e_pr = pr; v.e_rr = rr; v.e_uv = uv; v.e_ut = ut; v.e_ug = ug; v.e_fl = fl;
    v.e_rpc = rpc; v.e_gr = gr; v.e_cnt = cnt; v.e_pe = pe;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; pred_valid = 0; pred_taken = 0; pred_target = 0; pred_fallthru = 0; pred_ghr = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
  endtask

  task automatic push(input logic t, input logic [31:0] tgt, fall, input logic [2:0] g);
    pred_valid = 1; pred_taken = t; pred_target = tgt; pred_fallthru = fall; pred_ghr = g;
  endtask

  task automatic resolve(input logic t, input logic [31:0] tgt);
    res_valid = 1; res_taken = t; res_target = tgt;
  endtask

  logic [34:0] model_q[$];
  logic [34:0] head;

  initial begin
    idle();
    rst = 1;
    //   rst pv pt ptgt    pfall   pghr  rv rt rtgt     pr rr uv ut ug    fl rpc     gr     cnt pe
    add(1, 0, 0, 32'h0,   32'h0,   3'b000, 0, 0, 32'h0,   1, 0, 0, 0, 3'b000, 0, 32'h0,   3'b000, 0, 0);
    add(0, 1, 1, 32'h100, 32'h104, 3'b010, 0, 0, 32'h0,   1, 1, 0, 0, 3'b000, 0, 32'h0,   3'b000, 1, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 1, 1, 32'h100, 1, 0, 1, 1, 3'b010, 0, 32'h0,   3'b000, 0, 0);
    add(0, 1, 0, 32'h200, 32'h204, 3'b101, 0, 0, 32'h0,   1, 1, 0, 1, 3'b010, 0, 32'h0,   3'b000, 1, 0);
    add(0, 1, 1, 32'h400, 32'h304, 3'b011, 0, 0, 32'h0,   1, 1, 0, 1, 3'b010, 0, 32'h0,   3'b000, 2, 0);
    add(0, 1, 0, 32'h500, 32'h504, 3'b111, 0, 0, 32'h0,   1, 1, 0, 1, 3'b010, 0, 32'h0,   3'b000, 3, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 1, 1, 32'h300, 0, 0, 1, 1, 3'b101, 1, 32'h300, 3'b110, 0, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 0, 0, 32'h0,   1, 0, 0, 1, 3'b101, 0, 32'h300, 3'b110, 0, 0);
    add(0, 1, 1, 32'h100, 32'h104, 3'b001, 0, 0, 32'h0,   1, 1, 0, 1, 3'b101, 0, 32'h300, 3'b110, 1, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 1, 1, 32'h140, 0, 0, 1, 1, 3'b001, 1, 32'h140, 3'b100, 0, 0);
    add(0, 1, 1, 32'hAA0, 32'hAA4, 3'b111, 0, 0, 32'h0,   1, 0, 0, 1, 3'b001, 0, 32'h140, 3'b100, 0, 0);
    add(0, 1, 1, 32'h600, 32'h604, 3'b110, 0, 0, 32'h0,   1, 1, 0, 1, 3'b001, 0, 32'h140, 3'b100, 1, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 1, 0, 32'h0,   0, 0, 1, 0, 3'b110, 1, 32'h604, 3'b011, 0, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 0, 0, 32'h0,   1, 0, 0, 0, 3'b110, 0, 32'h604, 3'b011, 0, 0);
    add(0, 1, 0, 32'h700, 32'h704, 3'b000, 0, 0, 32'h0,   1, 1, 0, 0, 3'b110, 0, 32'h604, 3'b011, 1, 0);
    add(0, 1, 0, 32'hB00, 32'hB04, 3'b011, 1, 1, 32'h800, 0, 0, 1, 1, 3'b000, 1, 32'h800, 3'b100, 0, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 0, 0, 32'h0,   1, 0, 0, 1, 3'b000, 0, 32'h800, 3'b100, 0, 0);
    add(0, 1, 0, 32'h900, 32'h904, 3'b010, 0, 0, 32'h0,   1, 1, 0, 1, 3'b000, 0, 32'h800, 3'b100, 1, 0);
    add(0, 0, 0, 32'h0,   32'h0,   3'b000, 1, 0, 32'h123, 1, 0, 1, 0, 3'b010, 0, 32'h800, 3'b100, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; pred_valid = vecs[i].pv; pred_taken = vecs[i].pt;
      pred_target = vecs[i].ptgt; pred_fallthru = vecs[i].pfall; pred_ghr = vecs[i].pghr;
      res_valid = vecs[i].rv; res_taken = vecs[i].rt; res_target = vecs[i].rtgt;
      tick();
      chk($sformatf("v%0d pred_ready", i), 32'(pred_ready), 32'(vecs[i].e_pr));
      chk($sformatf("v%0d res_ready", i), 32'(res_ready), 32'(vecs[i].e_rr));
      chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
      chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
      chk($sformatf("v%0d upd_ghr", i), 32'(upd_ghr), 32'(vecs[i].e_ug));
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].e_fl));
      chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d ghr_restore", i), 32'(ghr_restore), 32'(vecs[i].e_gr));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d proto_err", i), 32'(proto_err), 32'(vecs[i].e_pe));
    end

    // Full queue, refused push alongside a pop, then pointer wrap.
    idle(); rst = 1; tick(); idle();
    for (int i = 0; i < 4; i++) begin
      push(1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 3'(i));
      model_q.push_back({3'(i), 32'h1000 + 32'(i)});
      tick();
    end
    idle();
    chk("full count", 32'(count), 32'd4);
    chk("full pred_ready", 32'(pred_ready), 32'd0);
    push(1, 32'hDEAD, 32'hDEAD, 3'b111);
    head = model_q.pop_front();
    resolve(1, head[31:0]);
    tick(); idle();
    chk("full pop count", 32'(count), 32'd3);
    chk("full pop upd_valid", 32'(upd_valid), 32'd1);
    chk("full pop upd_ghr", 32'(upd_ghr), 32'(head[34:32]));
    chk("full refused proto_err", 32'(proto_err), 32'd1);
    chk("full pop pred_ready", 32'(pred_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      push(1, 32'h3000 + 32'(k * 16), 32'h4000, 3'(k + 4));
      head = model_q.pop_front();
      model_q.push_back({3'(k + 4), 32'h3000 + 32'(k * 16)});
      resolve(1, head[31:0]);
      tick(); idle();
      chk($sformatf("wrap%0d flush", k), 32'(flush), 32'd0);
      chk($sformatf("wrap%0d upd_ghr", k), 32'(upd_ghr), 32'(head[34:32]));
      chk($sformatf("wrap%0d count", k), 32'(count), 32'd3);
    end
    while (model_q.size() > 0) begin
      head = model_q.pop_front();
      resolve(1, head[31:0]);
      tick(); idle();
      chk("drain flush", 32'(flush), 32'd0);
      chk("drain upd_ghr", 32'(upd_ghr), 32'(head[34:32]));
    end
    chk("drain count", 32'(count), 32'd0);

    // Pop on empty, then reset during RECOVER.
    idle(); rst = 1; tick(); idle();
    chk("rst proto_err", 32'(proto_err), 32'd0);
    resolve(1, 32'h0);
    tick(); idle();
    chk("empty pop proto_err", 32'(proto_err), 32'd1);
    chk("empty pop count", 32'(count), 32'd0);
    chk("empty pop upd_valid", 32'(upd_valid), 32'd0);
    tick();
    chk("proto_err sticky", 32'(proto_err), 32'd1);
    push(0, 32'h10, 32'h14, 3'b011);
    tick(); idle();
    resolve(1, 32'h50);
    tick(); idle();
    chk("recover flush", 32'(flush), 32'd1);
    chk("recover pred_ready", 32'(pred_ready), 32'd0);
    rst = 1;
    tick(); idle();
    chk("rst in recover pred_ready", 32'(pred_ready), 32'd1);
    chk("rst in recover res_ready", 32'(res_ready), 32'd0);
    chk("rst in recover flush", 32'(flush), 32'd0);
    chk("rst in recover proto_err", 32'(proto_err), 32'd0);
    chk("rst in recover redirect_pc", redirect_pc, 32'd0);
    chk("rst in recover count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight predicted branches (power of two, >=2).
REQ-002 SHALL have parameter GHR_W, default 3, global history width; matches the pattern-history predictor.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide the following ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- pred_valid  input  1  fetch pushes a predicted branch
- pred_taken  input  1  predicted direction
- pred_target  input  PC_W  predicted taken target
- pred_fallthru  input  PC_W  branch PC+4
- pred_ghr  input  GHR_W  GHR snapshot used for the prediction
- pred_ready  output  1  push accepted this cycle
- res_valid  input  1  execute resolves the oldest branch
- res_taken  input  1  actual direction
- res_target  input  PC_W  actual taken target
- res_ready  output  1  queue non-empty and state RUN
- upd_valid  output  1  predictor training strobe
- upd_taken  output  1  actual outcome for training
- upd_ghr  output  GHR_W  snapshot to index the counter table
- flush  output  1  mispredict flush pulse
- redirect_pc  output  PC_W  correct next PC, valid with flush
- ghr_restore  output  GHR_W  repaired GHR, valid with flush
- count  output  clog2(DEPTH)+1  entries held
- proto_err  output  1  sticky protocol error

Function
REQ-006 SHALL store entries {pred_taken, pred_target, pred_fallthru, pred_ghr} in a circular FIFO using wrapping read/write pointers, oldest first.
REQ-007 SHALL drive pred_ready = (state==RUN) && (count<DEPTH); the value SHALL NOT depend on res_valid in the same cycle.
REQ-008 SHALL push on an edge with pred_valid && pred_ready.
REQ-009 SHALL pop the head on an edge with res_valid && res_ready.
REQ-010 SHALL keep count unchanged on a simultaneous push and pop with no mispredict.
REQ-011 SHALL flag a mispredict on a pop when res_taken != head.pred_taken, or when both are taken and res_target != head.pred_target.
REQ-012 SHALL register all of upd_*, flush, redirect_pc and ghr_restore; each is valid in the cycle after the pop edge (latency 1).
REQ-013 SHALL pulse upd_valid for one cycle per pop, with upd_taken=res_taken and upd_ghr=head.pred_ghr.
REQ-014 SHALL, on a mispredict, set flush=1 for one cycle with:
- redirect_pc = res_taken ? res_target : head.pred_fallthru
- ghr_restore = {res_taken, head.pred_ghr[GHR_W-1:1]}
REQ-015 SHALL, on a mispredict, clear all entries (count=0, pointers equal); a push in the same cycle is discarded as wrong-path.
REQ-016 SHALL implement a two-state FSM:
- RUN goes to RECOVER on a mispredict pop.
- RECOVER goes to RUN unconditionally after one cycle.
- In RECOVER, pred_ready=0 and res_ready=0.
REQ-017 SHALL set proto_err, sticky until reset, on either event:
- res_valid while res_ready=0 in state RUN (the pop is ignored)
- pred_valid while pred_ready=0 in state RUN (the push is ignored)
REQ-018 SHALL hold redirect_pc and ghr_restore at their last values when flush=0.

Reset
REQ-019 SHALL, while rst=1 at an edge, set state=RUN, pointers=0, count=0, upd_valid=0, flush=0, upd_taken=0, upd_ghr=0, redirect_pc=0, ghr_restore=0, proto_err=0.
REQ-020 SHALL give rst priority over simultaneous push, pop and mispredict; an in-progress RECOVER SHALL be abandoned.
REQ-021 SHALL assert pred_ready=1 and res_ready=0 in the first cycle after reset release.

Verification
REQ-022 SHALL cover a correct prediction: push {taken=1, target=0x100, ghr=3'b010}, then res taken=1 target=0x100 -> next cycle upd_valid=1, upd_taken=1, upd_ghr=3'b010, flush=0, count=0.
REQ-023 SHALL cover a direction mispredict: push {taken=0, fallthru=0x204, ghr=3'b101} plus two more entries, then res taken=1 target=0x300 on the head -> flush=1, redirect_pc=0x300, ghr_restore=3'b110, count=0, pred_ready=0 for one cycle, then 1.
REQ-024 SHALL cover a target mispredict: push {taken=1, target=0x100}, res taken=1 target=0x140 -> flush=1, redirect_pc=0x140.
REQ-025 SHALL cover full and wrap: push 4 -> pred_ready=0, count=4; pop and push the same cycle -> push refused, count=3; run 10 push/pop pairs so pointers wrap -> FIFO order preserved.
REQ-026 SHALL cover errors and reset: res_valid on empty -> proto_err=1, count stays 0; rst during RECOVER -> next cycle state RUN, proto_err=0, flush=0.
